// File: rtl/pc_seq_unit.sv
// pc_seq_unit: program-counter sequencer with fixed-priority next-PC selection.
// Sources, highest first: exception entry, exception return, register-indirect
// jump, absolute jump, relative branch, sequential advance.
// Optional feature: define PC_RAS_EN to build a circular return-address stack
// (RAS_DEPTH entries) that is pushed on call-jumps and popped on return-jumps.
module pc_seq_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h0040_0000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0040_0004,
    parameter int unsigned      STEP      = 4,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             br_take,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jmp_take,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             jr_take,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             call,
    input  logic             ret,
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic [WIDTH-1:0] epc_out,
    output logic             in_exc,
    output logic             misalign
);

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_in_exc;
    logic             r_misalign;

    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_br_target;
    logic             w_exc_take;
    logic             w_eret_take;

    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_epc_nxt;
    logic             w_in_exc_nxt;
    logic             w_misalign_nxt;
    logic [WIDTH-1:0] w_redir;
    logic             w_redir_vld;

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W     = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RAS_SLOTS = 1 << PTR_W;

    logic [WIDTH-1:0] r_ras [RAS_SLOTS];
    logic [PTR_W-1:0] r_sp;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_push;
    logic             w_ras_pop;

    // Most recent entry sits just below the write pointer.
    assign w_ras_top = r_ras[r_sp - PTR_W'(1)];
`else
    // call/ret have no effect when the stack is not built.
    logic w_unused_ras;
    assign w_unused_ras = &{1'b0, call, ret};
`endif

    // Sequential and branch target arithmetic, wrapping modulo 2^WIDTH.
    assign w_seq       = r_pc + STEP_W;
    assign w_br_target = w_seq + br_offset;

    // Exception entry ignores ena; return needs ena and an active handler.
    assign w_exc_take  = exc_req && !r_in_exc;
    assign w_eret_take = ena && eret && r_in_exc;

    // Next-state selection with fixed priority and alignment fix-up.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_epc_nxt      = r_epc;
        w_in_exc_nxt   = r_in_exc;
        w_misalign_nxt = 1'b0;
        w_redir        = '0;
        w_redir_vld    = 1'b0;
`ifdef PC_RAS_EN
        w_ras_push     = 1'b0;
        w_ras_pop      = 1'b0;
`endif
        if (w_exc_take) begin
            w_pc_nxt     = EXC_VEC;
            w_epc_nxt    = r_pc;
            w_in_exc_nxt = 1'b1;
        end else if (ena) begin
            if (w_eret_take) begin
                w_pc_nxt     = r_epc;
                w_in_exc_nxt = 1'b0;
            end else if (jr_take) begin
                w_redir_vld = 1'b1;
                w_redir     = jr_target;
`ifdef PC_RAS_EN
                if (ret && (r_cnt != '0)) begin
                    w_redir   = w_ras_top;
                    w_ras_pop = 1'b1;
                end
`endif
            end else if (jmp_take) begin
                w_redir_vld = 1'b1;
                w_redir     = jmp_target;
`ifdef PC_RAS_EN
                w_ras_push  = call;
`endif
            end else if (br_take) begin
                w_redir_vld = 1'b1;
                w_redir     = w_br_target;
            end else begin
                w_pc_nxt = w_seq;
            end

            if (w_redir_vld) begin
                w_pc_nxt       = w_redir & ALIGN_MASK;
                w_misalign_nxt = |w_redir[1:0];
            end
        end
    end

    // Architectural state registers; reset overrides every request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_VEC;
            r_epc      <= '0;
            r_in_exc   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_nxt;
            r_epc      <= w_epc_nxt;
            r_in_exc   <= w_in_exc_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

`ifdef PC_RAS_EN
    // Circular return-address stack; a push when full overwrites the oldest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sp  <= '0;
            r_cnt <= '0;
        end else if (w_ras_push) begin
            r_ras[r_sp] <= w_seq;
            r_sp        <= r_sp + PTR_W'(1);
            if (r_cnt != CNT_W'(RAS_DEPTH)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (w_ras_pop) begin
            r_sp  <= r_sp - PTR_W'(1);
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end
`endif

    assign pc_out      = r_pc;
    assign pc_next_seq = w_seq;
    assign epc_out     = r_epc;
    assign in_exc      = r_in_exc;
    assign misalign    = r_misalign;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed vectors plus randomized traffic, checked by a
// scoreboard against an abstract next-PC model (queue-based return stack).
module tb_pc_seq_unit;

    localparam logic [31:0] RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] EXC_VEC   = 32'h0040_0004;
    localparam int          DEPTH     = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    typedef struct {
        bit          rst_n, ena, exc, eret, jr, jmp, br, call, ret;
        logic [31:0] jr_t, jmp_t, br_off;
    } stim_t;

    typedef struct {
        logic [31:0] pc, epc;
        logic        exc, mis;
        bit   [3:0]  lit;       // {pc, epc, in_exc, misalign} literal checks
        logic [31:0] lpc, lepc;
        logic        lexc, lmis;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic        br_take = 1'b0;
    logic [31:0] br_offset = '0;
    logic        jmp_take = 1'b0;
    logic [31:0] jmp_target = '0;
    logic        jr_take = 1'b0;
    logic [31:0] jr_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] pc_out, pc_next_seq, epc_out;
    logic        in_exc, misalign;

    pc_seq_unit #(
        .WIDTH(32), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC), .STEP(4), .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .br_take(br_take), .br_offset(br_offset),
        .jmp_take(jmp_take), .jmp_target(jmp_target),
        .jr_take(jr_take), .jr_target(jr_target),
        .call(call), .ret(ret), .exc_req(exc_req), .eret(eret),
        .pc_out(pc_out), .pc_next_seq(pc_next_seq), .epc_out(epc_out),
        .in_exc(in_exc), .misalign(misalign)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state.
    logic [31:0] m_pc = '0, m_epc = '0;
    logic        m_exc = 1'b0, m_mis = 1'b0;
    logic [31:0] m_ras[$];

    function automatic stim_t idle(input bit en);
        stim_t s;
        s = '{rst_n: 1'b1, ena: en, exc: 1'b0, eret: 1'b0, jr: 1'b0, jmp: 1'b0,
              br: 1'b0, call: 1'b0, ret: 1'b0, jr_t: '0, jmp_t: '0, br_off: '0};
        return s;
    endfunction

    // Advance the model by one clock for stimulus s.
    task automatic model_step(input stim_t s);
        logic [31:0] tgt;
        bit          redirect;
        tgt      = '0;
        redirect = 1'b1;
        if (!s.rst_n) begin
            m_pc = RESET_VEC; m_epc = '0; m_exc = 1'b0; m_mis = 1'b0;
            m_ras.delete();
        end else if (s.exc && !m_exc) begin
            m_epc = m_pc; m_pc = EXC_VEC; m_exc = 1'b1; m_mis = 1'b0;
        end else if (!s.ena) begin
            m_mis = 1'b0;
        end else if (s.eret && m_exc) begin
            m_pc = m_epc; m_exc = 1'b0; m_mis = 1'b0;
        end else begin
            if (s.jr) begin
                tgt = s.jr_t;
                if (RAS_ON && s.ret && m_ras.size() > 0) tgt = m_ras.pop_back();
            end else if (s.jmp) begin
                tgt = s.jmp_t;
                if (RAS_ON && s.call) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end else if (s.br) begin
                tgt = m_pc + 32'd4 + s.br_off;
            end else begin
                redirect = 1'b0;
                m_pc     = m_pc + 32'd4;
                m_mis    = 1'b0;
            end
            if (redirect) begin
                m_mis = (tgt % 4) != 0;
                m_pc  = tgt - (tgt % 4);
            end
        end
    endtask

    // Drive one cycle of stimulus and queue the expected response.
    task automatic step(input stim_t s, input bit [3:0] lit, input logic [31:0] lpc,
                        input logic [31:0] lepc, input logic lexc, input logic lmis,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst = s.rst_n; ena = s.ena; exc_req = s.exc; eret = s.eret;
        jr_take = s.jr; jr_target = s.jr_t; jmp_take = s.jmp; jmp_target = s.jmp_t;
        br_take = s.br; br_offset = s.br_off; call = s.call; ret = s.ret;
        model_step(s);
        e = '{pc: m_pc, epc: m_epc, exc: m_exc, mis: m_mis, lit: lit,
              lpc: lpc, lepc: lepc, lexc: lexc, lmis: lmis, tag: tag};
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle after the active edge, pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, " pc_out"},      pc_out,            e.pc);
                chk({e.tag, " pc_next_seq"}, pc_next_seq,       e.pc + 32'd4);
                chk({e.tag, " epc_out"},     epc_out,           e.epc);
                chk({e.tag, " in_exc"},      32'(in_exc),       32'(e.exc));
                chk({e.tag, " misalign"},    32'(misalign),     32'(e.mis));
                if (e.lit[3]) chk({e.tag, " lit_pc"},   pc_out,        e.lpc);
                if (e.lit[2]) chk({e.tag, " lit_epc"},  epc_out,       e.lepc);
                if (e.lit[1]) chk({e.tag, " lit_exc"},  32'(in_exc),   32'(e.lexc));
                if (e.lit[0]) chk({e.tag, " lit_mis"},  32'(misalign), 32'(e.lmis));
            end
        end
    end

    initial begin
        stim_t s;
        int    o;

        // Reset then sequential run.
        s = idle(1'b1); s.rst_n = 1'b0;
        step(s, 4'b1111, 32'h0040_0000, 32'h0, 1'b0, 1'b0, "reset");
        step(idle(1'b1), 4'b1000, 32'h0040_0004, 0, 0, 0, "seq1");
        step(idle(1'b1), 4'b1000, 32'h0040_0008, 0, 0, 0, "seq2");
        step(idle(1'b1), 4'b1000, 32'h0040_000C, 0, 0, 0, "seq3");
        step(idle(1'b1), 4'b1000, 32'h0040_0010, 0, 0, 0, "seq4");

        // Backward branch: stalled first, then taken.
        s = idle(1'b0); s.br = 1'b1; s.br_off = 32'hFFFF_FFF8;
        step(s, 4'b1001, 32'h0040_0010, 0, 0, 1'b0, "br_stall");
        s.ena = 1'b1;
        step(s, 4'b1001, 32'h0040_000C, 0, 0, 1'b0, "br_take");

        // Exception while stalled beats a jump; nested request masked; eret.
        s = idle(1'b1); s.jmp = 1'b1; s.jmp_t = 32'h0040_0020;
        step(s, 4'b1000, 32'h0040_0020, 0, 0, 0, "jmp");
        s = idle(1'b0); s.exc = 1'b1; s.jmp = 1'b1; s.jmp_t = 32'h0050_0000;
        step(s, 4'b1110, 32'h0040_0004, 32'h0040_0020, 1'b1, 0, "exc");
        s = idle(1'b1); s.exc = 1'b1;
        step(s, 4'b1110, 32'h0040_0008, 32'h0040_0020, 1'b1, 0, "exc_masked");
        s = idle(1'b1); s.eret = 1'b1;
        step(s, 4'b1010, 32'h0040_0020, 0, 1'b0, 0, "eret");
        s = idle(1'b1); s.eret = 1'b1;
        step(s, 4'b1010, 32'h0040_0024, 0, 1'b0, 0, "eret_ignored");

        // Misaligned indirect jump pulses misalign for one cycle.
        s = idle(1'b1); s.jr = 1'b1; s.jr_t = 32'h0040_0103;
        step(s, 4'b1001, 32'h0040_0100, 0, 0, 1'b1, "jr_mis");
        step(idle(1'b1), 4'b1001, 32'h0040_0104, 0, 0, 1'b0, "mis_clear");
        step(idle(1'b0), 4'b1001, 32'h0040_0104, 0, 0, 1'b0, "stall_hold");

        // Wrap at top of address space, then reset beats exception.
        s = idle(1'b1); s.jmp = 1'b1; s.jmp_t = 32'hFFFF_FFFC;
        step(s, 4'b1000, 32'hFFFF_FFFC, 0, 0, 0, "jmp_top");
        step(idle(1'b1), 4'b1000, 32'h0000_0000, 0, 0, 0, "wrap");
        s = idle(1'b1); s.exc = 1'b1;
        step(s, 4'b1010, 32'h0040_0004, 0, 1'b1, 0, "exc_pre_rst");
        s = idle(1'b1); s.rst_n = 1'b0; s.exc = 1'b1;
        step(s, 4'b1110, 32'h0040_0000, 32'h0, 1'b0, 0, "rst_over_exc");

`ifdef PC_RAS_EN
        // Five calls overflow a four-entry stack; five returns drain it.
        for (int i = 0; i < 5; i++) begin
            s = idle(1'b1); s.jmp = 1'b1; s.call = 1'b1;
            s.jmp_t = (i == 4) ? 32'h0060_0000 : 32'h0040_0010 * (i + 1);
            step(s, 4'b0000, 0, 0, 0, 0, "call");
        end
        for (int i = 0; i < 5; i++) begin
            s = idle(1'b1); s.jr = 1'b1; s.ret = 1'b1; s.jr_t = 32'h0050_0000;
            step(s, 4'b1000, (i == 4) ? 32'h0050_0000 : 32'h0040_0044 - 32'h10 * i,
                 0, 0, 0, "ret");
        end
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            s = idle($urandom_range(0, 99) < 80);
            s.rst_n = !($urandom_range(0, 99) < 2);
            s.exc   = $urandom_range(0, 99) < 5;
            s.eret  = $urandom_range(0, 99) < 12;
            s.jr    = $urandom_range(0, 99) < 10;
            s.jmp   = $urandom_range(0, 99) < 12;
            s.br    = $urandom_range(0, 99) < 15;
            s.call  = $urandom_range(0, 1) == 1;
            s.ret   = $urandom_range(0, 1) == 1;
            s.jr_t  = ($urandom_range(0, 3) == 0) ? $urandom
                                                  : 32'h0040_0000 + 32'($urandom_range(0, 1023));
            s.jmp_t = ($urandom_range(0, 3) == 0) ? $urandom
                                                  : 32'h0040_0000 + 32'($urandom_range(0, 1023));
            o = int'($urandom_range(0, 511)) - 256;
            s.br_off = ($urandom_range(0, 7) == 0) ? $urandom : 32'(o);
            step(s, 4'b0000, 0, 0, 0, 0, "rand");
        end

        // Drain the scoreboard within a bounded number of cycles.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
